// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - display codes, mode encodings and converter state type for seg_scan_driver
package seg_scan_pkg;

  // Display codes understood by the downstream segment decoder (0-9 are decimal digits)
  localparam logic [3:0] SEG_H     = 4'd10;
  localparam logic [3:0] SEG_E     = 4'd11;
  localparam logic [3:0] SEG_L     = 4'd12;
  localparam logic [3:0] SEG_O     = 4'd13;
  localparam logic [3:0] SEG_BLANK = 4'd14;
  localparam logic [3:0] SEG_DASH  = 4'd15;

  typedef enum logic [1:0] {
    MODE_MONEY = 2'd0,
    MODE_HELLO = 2'd1,
    MODE_PRICE = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } bcd_state_e;

  // 10**n, used for the overflow threshold of an n-digit BCD result
  function automatic longint pow10(input int n);
    longint v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - vending-side inputs and display-side outputs of seg_scan_driver
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int MONEY_W    = 8
);
  localparam int POS_W = $clog2(NUM_DIGITS);

  logic [MONEY_W-1:0] money;
  logic [3:0]         price;
  logic [1:0]         mode;
  logic [POS_W-1:0]   pos;
  logic [3:0]         num;
  logic               point;
  logic               busy;

  modport master (output money, price, mode, input pos, num, point, busy);
  modport slave  (input money, price, mode, output pos, num, point, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle double-dabble binary to BCD converter (IDLE/SHIFT/COMMIT)
module bin2bcd_seq
  import seg_scan_pkg::*;
#(
  parameter int MONEY_W      = 8,
  parameter int MONEY_DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [MONEY_W-1:0]           i_bin,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [MONEY_DIGITS-1:0][3:0] o_digits
);
  localparam int               CNT_W    = $clog2(MONEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MONEY_W - 1);
  localparam logic [63:0]      LIMIT    = 64'(pow10(MONEY_DIGITS));

  bcd_state_e                   r_state;
  bcd_state_e                   w_state_nxt;
  logic [MONEY_W-1:0]           r_shift;
  logic [MONEY_DIGITS-1:0][3:0] r_bcd;
  logic [MONEY_DIGITS-1:0][3:0] w_bcd_adj;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_ovf;

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: one start cycle, MONEY_W shift cycles, one commit cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == CNT_LAST) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: done marks the commit cycle; an out-of-range value reads as dashes
  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_COMMIT);
    for (int i = 0; i < MONEY_DIGITS; i++) begin
      o_digits[i] = r_ovf ? SEG_DASH : r_bcd[i];
    end
  end

  // Add-3 correction applied to every nibble before each shift
  always_comb begin
    for (int i = 0; i < MONEY_DIGITS; i++) begin
      w_bcd_adj[i] = (r_bcd[i] >= 4'd5) ? (r_bcd[i] + 4'd3) : r_bcd[i];
    end
  end

  // Datapath: latch the operand on start, then shift the binary MSB into the BCD field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= i_bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= (64'(i_bin) >= LIMIT);
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_cnt            <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - credit-to-BCD display buffer and digit scanner; SEG_SCAN_LZB_EN blanks leading money zeros
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int MONEY_W      = 8,
  parameter int MONEY_DIGITS = 3,
  parameter int DWELL        = 1
) (
  input  logic              clk_dvid,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);
  localparam int               POS_W    = $clog2(NUM_DIGITS);
  localparam int               DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

  logic [MONEY_W-1:0]           r_last_money;
  logic                         w_start;
  logic                         w_busy;
  logic                         w_done;
  logic [MONEY_DIGITS-1:0][3:0] w_bcd_digits;
  logic [MONEY_DIGITS-1:0][3:0] r_digit;
  logic [MONEY_DIGITS-1:0]      w_lead_zero;
  logic [DW_W-1:0]              r_dwell;
  logic                         w_wrap;
  logic [POS_W-1:0]             r_pos;
  logic [POS_W-1:0]             w_pos_nxt;
  logic [3:0]                   r_num;
  logic [3:0]                   w_num;
  logic                         r_point;
  logic                         w_point;

  // A new conversion starts only from idle; changes seen while busy are picked up afterwards
  assign w_start = !w_busy && (bus.money != r_last_money);

  bin2bcd_seq #(
    .MONEY_W      (MONEY_W),
    .MONEY_DIGITS (MONEY_DIGITS)
  ) u_bcd (
    .clk      (clk_dvid),
    .rst      (rst),
    .i_start  (w_start),
    .i_bin    (bus.money),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_digits (w_bcd_digits)
  );

  // Remember the value handed to the converter so the next change can be detected
  always_ff @(posedge clk_dvid or posedge rst) begin
    if (rst)          r_last_money <= '0;
    else if (w_start) r_last_money <= bus.money;
  end

  // Display digit buffer, updated all at once on the commit cycle
  always_ff @(posedge clk_dvid or posedge rst) begin
    if (rst)         r_digit <= '0;
    else if (w_done) r_digit <= w_bcd_digits;
  end

  // Leading-zero mask over money digits, scanning down from the most significant one
`ifdef SEG_SCAN_LZB_EN
  always_comb begin : lz_mask
    logic w_run;
    w_run       = 1'b1;
    w_lead_zero = '0;
    for (int i = MONEY_DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run && (r_digit[i] == 4'd0);
      w_lead_zero[i] = w_run;
    end
  end
`else
  assign w_lead_zero = '0;
`endif

  // Scan sequencing: dwell wrap and the next digit position
  always_comb begin
    w_wrap    = (r_dwell == DW_LAST);
    w_pos_nxt = (r_pos == POS_LAST) ? '0 : (r_pos + 1'b1);
  end

  // Code and point for the digit about to be shown, by display mode
  always_comb begin
    w_num   = SEG_BLANK;
    w_point = 1'b0;
    case (mode_e'(bus.mode))
      MODE_MONEY: begin
        for (int i = 0; i < MONEY_DIGITS; i++) begin
          if (w_pos_nxt == POS_W'(i)) begin
            w_num   = (i >= 2 && w_lead_zero[i]) ? SEG_BLANK : r_digit[i];
            w_point = (i == 1);
          end
        end
      end
      MODE_HELLO: begin
        case (int'(w_pos_nxt))
          0:       w_num = SEG_O;
          1, 2:    w_num = SEG_L;
          3:       w_num = SEG_E;
          4:       w_num = SEG_H;
          default: w_num = SEG_BLANK;
        endcase
      end
      MODE_PRICE: begin
        if (w_pos_nxt == POS_LAST)                       w_num = bus.price;
        else if (w_pos_nxt == '0 && bus.price == 4'd0)   w_num = SEG_DASH;
      end
      default: ;
    endcase
  end

  // Scan registers: pos, num and point change on the same edge so they always agree
  always_ff @(posedge clk_dvid or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
      r_pos   <= '0;
      r_num   <= SEG_BLANK;
      r_point <= 1'b0;
    end else if (w_wrap) begin
      r_dwell <= '0;
      r_pos   <= w_pos_nxt;
      r_num   <= w_num;
      r_point <= w_point;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  assign bus.pos   = r_pos;
  assign bus.num   = r_num;
  assign bus.point = r_point;
  assign bus.busy  = w_busy;

endmodule
